cam_ctrl: RTL and testbench

Single-requester sequencer for the CAM array and its address decoder. It accepts one command at a time (READ, WRITE, SEARCH, INVALIDATE) over a valid/ready handshake and strobes the decoder's read, write and search enables for exactly one cycle. It samples the array's read data and match vector, masks matches with a per-entry valid-bit register, and priority-encodes the hit. It returns one response per command over a second valid/ready handshake.

---
 rtl/cam_pkg.sv | 26 ++
 rtl/cam_prio_enc.sv | 23 ++
 rtl/cam_ctrl.sv | 147 ++++++++++++++
 tb/tb_cam_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared opcodes and state encodings for the CAM sequencer.
//   OPC_*        : 2-bit command opcodes as seen on cmd_op_i
//   cam_op_e     : typed view of the opcode
//   cam_state_e  : sequencer FSM states
package cam_pkg;

   localparam logic [1:0] OPC_READ   = 2'd0;
   localparam logic [1:0] OPC_WRITE  = 2'd1;
   localparam logic [1:0] OPC_SEARCH = 2'd2;
   localparam logic [1:0] OPC_INVAL  = 2'd3;

   typedef enum logic [1:0] {
      OP_READ   = OPC_READ,
      OP_WRITE  = OPC_WRITE,
      OP_SEARCH = OPC_SEARCH,
      OP_INVAL  = OPC_INVAL
   } cam_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_CAPT,
      ST_RESP
   } cam_state_e;

endpackage

// File: rtl/cam_prio_enc.sv
// cam_prio_enc: lowest-index priority encoder for a CAM match vector.
//   match [DEPTH]      : masked match vector
//   index [ADDR_WIDTH] : index of the lowest set bit, 0 when none set
//   found              : any bit set
module cam_prio_enc #(
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]      match,
   output logic [ADDR_WIDTH-1:0] index,
   output logic                  found
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      index = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (match[i]) index = ADDR_WIDTH'(i);
   end

   assign found = |match;

endmodule

// File: rtl/cam_ctrl.sv
// cam_ctrl: single-requester sequencer for a CAM array and its address decoder.
//   clk_i, reset_n_i          : clock (rising edge), async active-low reset
//   cmd_valid_i/cmd_ready_o   : command handshake; cmd_op_i, cmd_index_i, cmd_data_i
//   read_enable_o/read_index_o                  : decoder read strobe and index
//   write_enable_o/write_index_o/write_data_o   : decoder write strobe, index, data
//   search_enable_o/search_data_o               : decoder search strobe and key
//   cam_read_data_i           : array read data, one cycle after read strobe
//   cam_match_i               : raw match vector, one cycle after search strobe
//   rsp_valid_o/rsp_ready_i   : response handshake; rsp_hit_o, rsp_index_o, rsp_data_o
//   valid_o                   : per-entry valid bits
module cam_ctrl
   import cam_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 1 << ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [1:0]            cmd_op_i,
   input  logic [ADDR_WIDTH-1:0] cmd_index_i,
   input  logic [WIDTH-1:0]      cmd_data_i,
   output logic                  read_enable_o,
   output logic [ADDR_WIDTH-1:0] read_index_o,
   output logic                  write_enable_o,
   output logic [ADDR_WIDTH-1:0] write_index_o,
   output logic [WIDTH-1:0]      write_data_o,
   output logic                  search_enable_o,
   output logic [WIDTH-1:0]      search_data_o,
   input  logic [WIDTH-1:0]      cam_read_data_i,
   input  logic [DEPTH-1:0]      cam_match_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic                  rsp_hit_o,
   output logic [ADDR_WIDTH-1:0] rsp_index_o,
   output logic [WIDTH-1:0]      rsp_data_o,
   output logic [DEPTH-1:0]      valid_o
);

   cam_state_e            state;
   cam_op_e               op_q;
   logic [ADDR_WIDTH-1:0] index_q;
   logic [ADDR_WIDTH-1:0] hit_index;
   logic                  hit_found;

   // Matches on entries that are not valid never count as hits.
   cam_prio_enc #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_prio_enc (
      .match (cam_match_i & valid_o),
      .index (hit_index),
      .found (hit_found)
   );

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state           <= ST_IDLE;
         op_q            <= OP_READ;
         index_q         <= '0;
         cmd_ready_o     <= 1'b0;
         read_enable_o   <= 1'b0;
         read_index_o    <= '0;
         write_enable_o  <= 1'b0;
         write_index_o   <= '0;
         write_data_o    <= '0;
         search_enable_o <= 1'b0;
         search_data_o   <= '0;
         rsp_valid_o     <= 1'b0;
         rsp_hit_o       <= 1'b0;
         rsp_index_o     <= '0;
         rsp_data_o      <= '0;
         valid_o         <= '0;
      end else begin
         case (state)
            // Strobes and decoder-facing outputs are loaded on acceptance so
            // they are registered and valid for the whole EXEC cycle.
            ST_IDLE: begin
               if (cmd_valid_i && cmd_ready_o) begin
                  op_q        <= cam_op_e'(cmd_op_i);
                  index_q     <= cmd_index_i;
                  cmd_ready_o <= 1'b0;
                  state       <= ST_EXEC;
                  case (cam_op_e'(cmd_op_i))
                     OP_READ: begin
                        read_enable_o <= 1'b1;
                        read_index_o  <= cmd_index_i;
                     end
                     OP_WRITE: begin
                        write_enable_o <= 1'b1;
                        write_index_o  <= cmd_index_i;
                        write_data_o   <= cmd_data_i;
                     end
                     OP_SEARCH: begin
                        search_enable_o <= 1'b1;
                        search_data_o   <= cmd_data_i;
                     end
                     OP_INVAL: ;
                  endcase
               end else begin
                  cmd_ready_o <= 1'b1;
               end
            end
            ST_EXEC: begin
               read_enable_o   <= 1'b0;
               write_enable_o  <= 1'b0;
               search_enable_o <= 1'b0;
               if (op_q == OP_WRITE) valid_o[index_q] <= 1'b1;
               if (op_q == OP_INVAL) valid_o[index_q] <= 1'b0;
               state <= ST_CAPT;
            end
            // Array outputs answer the EXEC strobe during this cycle.
            ST_CAPT: begin
               case (op_q)
                  OP_READ: begin
                     rsp_hit_o   <= valid_o[index_q];
                     rsp_index_o <= index_q;
                     rsp_data_o  <= cam_read_data_i;
                  end
                  OP_SEARCH: begin
                     rsp_hit_o   <= hit_found;
                     rsp_index_o <= hit_index;
                     rsp_data_o  <= '0;
                  end
                  default: begin
                     rsp_hit_o   <= 1'b1;
                     rsp_index_o <= index_q;
                     rsp_data_o  <= '0;
                  end
               endcase
               rsp_valid_o <= 1'b1;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: directed scoreboard bench for cam_ctrl with a behavioural CAM array.
module tb_cam_ctrl;

   localparam int WIDTH = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   typedef struct {
      logic          hit;
      logic [AW-1:0] idx;
      logic [31:0]   data;
   } exp_t;

   logic             clk_i = 1'b0;
   logic             reset_n_i;
   logic             cmd_valid_i;
   logic             cmd_ready_o;
   logic [1:0]       cmd_op_i;
   logic [AW-1:0]    cmd_index_i;
   logic [WIDTH-1:0] cmd_data_i;
   logic             read_enable_o;
   logic [AW-1:0]    read_index_o;
   logic             write_enable_o;
   logic [AW-1:0]    write_index_o;
   logic [WIDTH-1:0] write_data_o;
   logic             search_enable_o;
   logic [WIDTH-1:0] search_data_o;
   logic [WIDTH-1:0] cam_read_data_i;
   logic [DEPTH-1:0] cam_match_i;
   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic             rsp_hit_o;
   logic [AW-1:0]    rsp_index_o;
   logic [WIDTH-1:0] rsp_data_o;
   logic [DEPTH-1:0] valid_o;

   int               checks = 0;
   int               errors = 0;
   exp_t             q[$];
   exp_t             mon_e;
   logic [31:0]      mem [DEPTH];
   logic             filled = 1'b0;
   logic [DEPTH-1:0] vm = '0;

   cam_ctrl #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk_i           (clk_i),
      .reset_n_i       (reset_n_i),
      .cmd_valid_i     (cmd_valid_i),
      .cmd_ready_o     (cmd_ready_o),
      .cmd_op_i        (cmd_op_i),
      .cmd_index_i     (cmd_index_i),
      .cmd_data_i      (cmd_data_i),
      .read_enable_o   (read_enable_o),
      .read_index_o    (read_index_o),
      .write_enable_o  (write_enable_o),
      .write_index_o   (write_index_o),
      .write_data_o    (write_data_o),
      .search_enable_o (search_enable_o),
      .search_data_o   (search_data_o),
      .cam_read_data_i (cam_read_data_i),
      .cam_match_i     (cam_match_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_ready_i     (rsp_ready_i),
      .rsp_hit_o       (rsp_hit_o),
      .rsp_index_o     (rsp_index_o),
      .rsp_data_o      (rsp_data_o),
      .valid_o         (valid_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Array model: answers strobes one cycle later, garbage otherwise.
   always @(posedge clk_i) begin
      if (!filled) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA500_0000 | i;
         filled <= 1'b1;
      end else if (write_enable_o) begin
         mem[write_index_o] <= write_data_o;
      end
      cam_read_data_i <= read_enable_o ? mem[read_index_o] : $urandom;
      if (search_enable_o)
         for (int i = 0; i < DEPTH; i++) cam_match_i[i] <= (mem[i] == search_data_o);
      else
         cam_match_i <= $urandom;
   end

   always @(negedge clk_i) begin
      chk("strobe_onehot", 64'($countones({read_enable_o, write_enable_o, search_enable_o}) <= 1), 1);
      if (reset_n_i && rsp_valid_o && rsp_ready_i) begin
         if (q.size() == 0) chk("rsp_unexpected", 1, 0);
         else begin
            mon_e = q.pop_front();
            chk("rsp_hit", rsp_hit_o, mon_e.hit);
            chk("rsp_index", rsp_index_o, mon_e.idx);
            chk("rsp_data", rsp_data_o, mon_e.data);
         end
      end
   end

   task automatic handshake(input logic [1:0] op, input logic [AW-1:0] idx, input logic [31:0] data);
      int k;
      @(posedge clk_i); #1;
      cmd_op_i = op; cmd_index_i = idx; cmd_data_i = data; cmd_valid_i = 1'b1;
      for (k = 0; k < 20; k++) begin
         @(negedge clk_i);
         if (cmd_ready_o) break;
      end
      chk("cmd_ready_timeout", 64'(k < 20), 1);
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
      @(negedge clk_i);
   endtask

   // Pushes the expected response, then walks EXEC, CAPT and RESP; returns in RESP.
   task automatic send(input logic [1:0] op, input logic [AW-1:0] idx, input logic [31:0] data);
      exp_t e;
      e.hit = 1'b1; e.idx = idx; e.data = '0;
      if (op == 2'd0) begin e.hit = vm[idx]; e.data = mem[idx]; end
      if (op == 2'd2) begin
         e.hit = 1'b0; e.idx = '0;
         for (int i = DEPTH - 1; i >= 0; i--)
            if (vm[i] && mem[i] == data) begin e.hit = 1'b1; e.idx = AW'(i); end
      end
      if (op == 2'd1) vm[idx] = 1'b1;
      if (op == 2'd3) vm[idx] = 1'b0;
      q.push_back(e);
      handshake(op, idx, data);
      chk("exec_strobes", {read_enable_o, write_enable_o, search_enable_o},
          op == 2'd0 ? 3'b100 : op == 2'd1 ? 3'b010 : op == 2'd2 ? 3'b001 : 3'b000);
      if (op == 2'd0) chk("read_index", read_index_o, idx);
      if (op == 2'd1) chk("write_addr_data", {write_index_o, write_data_o}, {idx, data});
      if (op == 2'd2) chk("search_data", search_data_o, data);
      @(negedge clk_i);
      chk("capt_strobes_rsp", {read_enable_o, write_enable_o, search_enable_o, rsp_valid_o}, 0);
      @(negedge clk_i);
      chk("resp_valid", rsp_valid_o, 1);
   endtask

   task automatic wait_done();
      for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk_i);
      chk("rsp_timeout", q.size(), 0);
   endtask

   initial begin
      reset_n_i = 1'b0; cmd_valid_i = 1'b0; rsp_ready_i = 1'b1;
      cmd_op_i = '0; cmd_index_i = '0; cmd_data_i = '0;
      repeat (3) @(negedge clk_i);
      chk("reset_ctrl", {cmd_ready_o, rsp_valid_o, read_enable_o, write_enable_o, search_enable_o}, 0);
      chk("reset_valid", valid_o, 0);
      chk("reset_rsp", {rsp_hit_o, rsp_index_o, rsp_data_o}, 0);
      chk("reset_idx", {read_index_o, write_index_o}, 0);
      chk("reset_data", {write_data_o, search_data_o}, 0);
      reset_n_i = 1'b1;

      send(2'd1, 5'd5, 32'hDEAD_BEEF); wait_done();
      chk("valid_after_write5", valid_o, vm);

      // Reset while a SEARCH is in EXEC: everything clears, no response follows.
      handshake(2'd2, 5'd0, 32'hDEAD_BEEF);
      chk("abort_exec_strobe", search_enable_o, 1);
      reset_n_i = 1'b0; #1;
      chk("abort_strobes", {read_enable_o, write_enable_o, search_enable_o, cmd_ready_o}, 0);
      chk("abort_valid", valid_o, 0);
      vm = '0;
      @(negedge clk_i); reset_n_i = 1'b1;
      repeat (8) begin
         @(negedge clk_i);
         chk("abort_no_rsp", rsp_valid_o, 0);
      end

      send(2'd1, 5'd5, 32'hDEAD_BEEF); wait_done();
      chk("valid5", valid_o[5], 1);
      send(2'd0, 5'd5, 32'h0); wait_done();
      send(2'd0, 5'd6, 32'h0); wait_done();

      send(2'd1, 5'd3, 32'h1234); wait_done();
      send(2'd1, 5'd9, 32'h1234); wait_done();
      send(2'd2, 5'd0, 32'h1234); wait_done();
      send(2'd3, 5'd3, 32'h0); wait_done();
      send(2'd2, 5'd0, 32'h1234); wait_done();
      send(2'd3, 5'd3, 32'h0); wait_done();

      send(2'd1, 5'd31, 32'h5555); wait_done();
      send(2'd3, 5'd31, 32'h0); wait_done();
      send(2'd2, 5'd0, 32'h5555); wait_done();
      send(2'd1, 5'd31, 32'h5555); wait_done();
      send(2'd1, 5'd31, 32'h5555); wait_done();
      chk("valid_after_overwrite", valid_o, vm);
      send(2'd2, 5'd0, 32'h5555); wait_done();

      // Backpressure, with a competing command that must not be accepted.
      @(posedge clk_i); #1 rsp_ready_i = 1'b0;
      send(2'd0, 5'd9, 32'h0);
      @(posedge clk_i); #1;
      cmd_op_i = 2'd1; cmd_index_i = 5'd0; cmd_data_i = 32'h7777; cmd_valid_i = 1'b1;
      repeat (10) begin
         @(negedge clk_i);
         chk("bp_ctrl", {rsp_valid_o, cmd_ready_o, read_enable_o, write_enable_o, search_enable_o}, 5'b10000);
         chk("bp_rsp", {rsp_hit_o, rsp_index_o, rsp_data_o}, {1'b1, 5'd9, 32'h1234});
      end
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0; rsp_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("bp_release", {cmd_ready_o, rsp_valid_o}, 2'b10);
      wait_done();
      chk("bp_no_accept", valid_o, vm);

      // Clean reset in IDLE then search with nothing valid.
      @(negedge clk_i); reset_n_i = 1'b0; #1;
      chk("reset2_valid", valid_o, 0);
      vm = '0;
      @(negedge clk_i); reset_n_i = 1'b1;
      send(2'd2, 5'd0, 32'h1234); wait_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
